// File: rtl/mul_unit.sv
// Sequential shift-add multiplier: one add/shift iteration per clock, fixed WIDTH-cycle latency.
// Result and flags are registered and held in DONE until the next load or a clear.
module mul_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mult_reset,
  input  logic               mult_load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               mult_done,
  output logic               busy,
  output logic [WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0] product_full,
  output logic               ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, next_state;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] sum;
  logic               last;
  logic [2*WIDTH-1:0] result;
  logic               ovf_q;

  assign sum  = acc + (mplr[0] ? mcand : '0);
  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Loads are only honoured from IDLE/DONE, so a second load cycle during RUN is ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mult_load) next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    if (mult_load) next_state = RUN;
      default: next_state = IDLE;
    endcase
    if (mult_reset) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      ovf_q  <= 1'b0;
    end else if (mult_reset) begin
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (mult_load) begin
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          // The final partial sum goes straight to the result so it is valid with mult_done.
          if (last) begin
            result <= sum;
            ovf_q  <= |sum[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state == RUN);
  assign mult_done    = (state == DONE);
  assign product_full = result;
  assign product      = result[WIDTH-1:0];
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit: latency, arithmetic, reload from DONE and aborts.
module tb_mul_unit;

  logic        clk;
  logic        rst;
  logic        mult_reset;
  logic        mult_load;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        mult_done;
  logic        busy;
  logic [7:0]  product;
  logic [15:0] product_full;
  logic        ovf;

  int checks;
  int failures;

  mul_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mult_reset   (mult_reset),
    .mult_load    (mult_load),
    .a            (a),
    .b            (b),
    .mult_done    (mult_done),
    .busy         (busy),
    .product      (product),
    .product_full (product_full),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the load edge until mult_done, bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(input int start, output int cycles, output bit busy_ok);
    cycles  = start;
    busy_ok = 1'b1;
    while (mult_done !== 1'b1 && cycles < 30) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cycles++;
    end
  endtask

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    mult_load = 1'b1;
    tick();
    mult_load = 1'b0;
  endtask

  task automatic controller_clear();
    mult_reset = 1'b1;
    tick();
    tick();
    mult_reset = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mult_reset = 1'b0;
    mult_load = 1'b0;
    a = 8'h00;
    b = 8'h00;
    #12;
    checks++;
    if ({mult_done, busy, ovf} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got done/busy/ovf=%b expected 000", {mult_done, busy, ovf});
    end
    checks++;
    if (product_full !== 16'h0000 || product !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_product: got full=%h prod=%h expected 0000/00", product_full, product);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({mult_done, busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got done/busy=%b expected 00", {mult_done, busy});
    end
  endtask

  task automatic test_controller_seq();
    int  n;
    bit  bok;
    controller_clear();
    a = 8'd3;
    b = 8'd5;
    mult_load = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || mult_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL seq_busy_start: got busy=%b done=%b expected 1/0", busy, mult_done);
    end
    tick();
    mult_load = 1'b0;
    a = 8'h55;
    b = 8'hAA;
    wait_done(1, n, bok);
    checks++;
    if (n !== 8) begin
      failures++;
      $display("[TB] FAIL seq_latency: got %0d expected 8", n);
    end
    checks++;
    if (bok !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL seq_busy_window: got ok=%b busy_at_done=%b expected 1/0", bok, busy);
    end
    checks++;
    if (product !== 8'd15 || product_full !== 16'd15 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL seq_result: got prod=%h full=%h ovf=%b expected 0f/000f/0", product, product_full, ovf);
    end
    tick();
    tick();
    checks++;
    if (mult_done !== 1'b1 || product_full !== 16'd15) begin
      failures++;
      $display("[TB] FAIL seq_hold: got done=%b full=%h expected 1/000f", mult_done, product_full);
    end
  endtask

  task automatic test_arith(input logic [7:0] av, input logic [7:0] bv,
                            input logic [15:0] exp_full, input logic exp_ovf, input string name);
    int n;
    bit bok;
    controller_clear();
    start_op(av, bv);
    wait_done(0, n, bok);
    checks++;
    if (n !== 8 || bok !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_latency: got %0d busy_ok=%b expected 8/1", name, n, bok);
    end
    checks++;
    if (product_full !== exp_full || product !== exp_full[7:0] || ovf !== exp_ovf) begin
      failures++;
      $display("[TB] FAIL %s_result: got full=%h prod=%h ovf=%b expected %h/%h/%b",
               name, product_full, product, ovf, exp_full, exp_full[7:0], exp_ovf);
    end
  endtask

  task automatic test_reload_from_done();
    int n;
    bit bok;
    test_arith(8'h00, 8'hA5, 16'h0000, 1'b0, "zero");
    start_op(8'd7, 8'd9);
    checks++;
    if (mult_done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reload_drop: got done=%b busy=%b expected 0/1", mult_done, busy);
    end
    wait_done(0, n, bok);
    checks++;
    if (n !== 8 || product_full !== 16'd63 || product !== 8'd63 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reload_result: got n=%0d full=%h ovf=%b expected 8/003f/0", n, product_full, ovf);
    end
  endtask

  task automatic test_mult_reset_abort();
    bit done_seen;
    controller_clear();
    start_op(8'd6, 8'd7);
    tick();
    tick();
    tick();
    mult_reset = 1'b1;
    mult_load = 1'b1;
    tick();
    mult_reset = 1'b0;
    mult_load = 1'b0;
    checks++;
    if ({mult_done, busy, ovf} !== 3'b000 || product_full !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL mreset_clear: got done/busy/ovf=%b full=%h expected 000/0000",
               {mult_done, busy, ovf}, product_full);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mult_done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
      tick();
    end
    checks++;
    if (done_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mreset_stays_idle: got activity=%b expected 0", done_seen);
    end
    test_arith(8'd6, 8'd7, 16'd42, 1'b0, "after_mreset");
  endtask

  task automatic test_async_abort();
    bit done_seen;
    controller_clear();
    start_op(8'd10, 8'd10);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({mult_done, busy, ovf} !== 3'b000 || product_full !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL rst_async_clear: got done/busy/ovf=%b full=%h expected 000/0000",
               {mult_done, busy, ovf}, product_full);
    end
    tick();
    rst = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mult_done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_no_resume: got activity=%b expected 0", done_seen);
    end
    test_arith(8'd10, 8'd10, 16'd100, 1'b0, "after_rst");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_controller_seq();
    test_arith(8'hFF, 8'hFF, 16'hFE01, 1'b1, "ff_ff");
    test_arith(8'hFE, 8'h03, 16'h02FA, 1'b1, "neg2_3");
    test_reload_from_done();
    test_mult_reset_abort();
    test_async_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
